// File: rtl/dm_pkg.sv
// Shared definitions for the MEM-stage data path: load encodings, FSM states
// and store-lane placement.
package dm_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 10;
    localparam int unsigned LANES          = 4;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_e;

    // Replicate sb/sh data so the enabled lanes pick it up wherever they sit.
    function automatic logic [31:0] place_lanes(input logic [3:0] be, input logic [31:0] wdata);
        logic one_hot;
        one_hot = (be != 4'b0000) && ((be & 4'(be - 4'd1)) == 4'b0000);
        if (one_hot)
            return {4{wdata[7:0]}};
        else if (be == 4'b0011 || be == 4'b1100)
            return {2{wdata[15:0]}};
        else
            return wdata;
    endfunction

endpackage

// File: rtl/ld_ext.sv
// Load aligner: picks the half/byte addressed by off, extends it, and flags
// misaligned word/half loads.
module ld_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  ld_type,
    output logic [31:0] rdata,
    output logic        ld_err
);

    logic [15:0] half;
    logic [7:0]  byte_v;

    assign half   = off[1] ? word[31:16] : word[15:0];
    assign byte_v = word[{off, 3'b000} +: 8];

    always_comb begin
        rdata  = '0;
        ld_err = 1'b0;
        case (ld_type)
            LD_LW: begin
                if (off != 2'b00) ld_err = 1'b1;
                else              rdata  = word;
            end
            LD_LH: begin
                if (off[0]) ld_err = 1'b1;
                else        rdata  = {{16{half[15]}}, half};
            end
            LD_LHU: begin
                if (off[0]) ld_err = 1'b1;
                else        rdata  = {16'h0000, half};
            end
            LD_LB:   rdata = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  rdata = {24'h000000, byte_v};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/dm_byte_ram.sv
// Byte-lane data memory with a post-reset self-clear sequence and aligned,
// extended load data.
module dm_byte_ram
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_type,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        oob,
    output logic        ld_err
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] widx;
    logic [31:0]           wdata_lane;
    logic [31:0]           word;
    logic [31:0]           ext_rdata;
    logic                  wr_en;
    logic [31:0]           mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear walks cnt across the array once, then parks in READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d = S_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end
    end

    assign busy       = (state_q == S_CLEAR);
    assign oob        = |addr[31:ADDR_WIDTH+2];
    assign widx       = addr[ADDR_WIDTH+1:2];
    assign wdata_lane = place_lanes(be, wdata);
    assign wr_en      = we && !busy && !oob && (be != 4'b0000);

    // Array has no reset; the clear sequence is the only initialisation.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_lane[8*i +: 8];
            end
        end
    end

    assign word = mem[widx];

    ld_ext u_ld_ext (
        .word    (word),
        .off     (addr[1:0]),
        .ld_type (ld_type),
        .rdata   (ext_rdata),
        .ld_err  (ld_err)
    );

    assign rdata = (busy || oob) ? '0 : ext_rdata;

endmodule

// File: tb/tb_dm_byte_ram.sv
// Directed bench for dm_byte_ram: expected read results are queued as each
// read is driven and compared when the output is sampled.
module tb_dm_byte_ram;
    import dm_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ld_type;
    logic [31:0] rdata;
    logic        busy;
    logic        oob;
    logic        ld_err;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        err;
        logic        oob;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    dm_byte_ram #(.ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .be      (be),
        .addr    (addr),
        .wdata   (wdata),
        .ld_type (ld_type),
        .rdata   (rdata),
        .busy    (busy),
        .oob     (oob),
        .ld_err  (ld_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a load, queue its expectation, compare at the falling edge.
    task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] t,
                      input logic [31:0] exp_d, input logic exp_e, input logic exp_o);
        exp_t e;
        we      = 1'b0;
        be      = 4'b0000;
        addr    = a;
        ld_type = t;
        sb.push_back('{tag, exp_d, exp_e, exp_o});
        @(negedge clk);
        e = sb.pop_front();
        check({e.tag, ".rdata"}, rdata, e.data);
        check({e.tag, ".ld_err"}, 32'(ld_err), 32'(e.err));
        check({e.tag, ".oob"}, 32'(oob), 32'(e.oob));
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        we    = 1'b1;
        be    = b;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        be = 4'b0000;
    endtask

    // Busy must stay high for exactly DEPTH edges after release.
    task automatic wait_clear(input string tag);
        check({tag, ".busy_rel"}, 32'(busy), 32'd1);
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s.busy_e%0d", tag, k), 32'(busy), (k < DEPTH) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst_n   = 1'b1;
        we      = 1'b0;
        be      = 4'b0000;
        addr    = 32'h0;
        wdata   = 32'h0;
        ld_type = LD_LW;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset state: busy gates rdata, oob/ld_err follow inputs.
        check("rst.busy", 32'(busy), 32'd1);
        rd("rst.rd0", 32'h0, LD_LW, 32'h0, 1'b0, 1'b0);
        rd("rst.oob", 32'h4000, LD_LW, 32'h0, 1'b0, 1'b1);
        rd("rst.err", 32'h11, LD_LW, 32'h0, 1'b1, 1'b0);

        // First clear, with a store attempted mid-clear to a cleared word.
        rst_n = 1'b1;
        check("clr1.busy_rel", 32'(busy), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
        end
        st(32'h0, 4'b1111, 32'hBAADF00D);
        for (int k = 7; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("clr1.busy_e%0d", k), 32'(busy), (k < DEPTH) ? 32'd1 : 32'd0);
        end
        rd("clr1.drop_busy", 32'h0, LD_LW, 32'h0, 1'b0, 1'b0);

        // Fill with junk, then reset, and reset again at cnt=7.
        for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 4'b1111, 32'hA5A50000 + 32'(i));
        rd("junk.w5", 32'h14, LD_LW, 32'hA5A50005, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid.busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid.busy_rst", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_clear("clr2");
        for (int i = 0; i < DEPTH; i++)
            rd($sformatf("clr2.w%0d", i), 32'(i * 4), LD_LW, 32'h0, 1'b0, 1'b0);

        // Word store with read-during-write showing old data.
        we = 1'b1; be = 4'b1111; addr = 32'h10; wdata = 32'hDEADBEEF; ld_type = LD_LW;
        @(negedge clk);
        check("rdw.old", rdata, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        rd("sw.lw", 32'h10, LD_LW, 32'hDEADBEEF, 1'b0, 1'b0);

        // Byte store and signed/unsigned byte loads.
        st(32'h12, 4'b0100, 32'h00000080);
        rd("sb.lw", 32'h10, LD_LW, 32'hDE80BEEF, 1'b0, 1'b0);
        rd("sb.lb", 32'h12, LD_LB, 32'hFFFFFF80, 1'b0, 1'b0);
        rd("sb.lbu", 32'h12, LD_LBU, 32'h00000080, 1'b0, 1'b0);

        // Half store and half/byte loads.
        st(32'h12, 4'b1100, 32'h00001234);
        rd("sh.lw", 32'h10, LD_LW, 32'h1234BEEF, 1'b0, 1'b0);
        rd("sh.lh", 32'h10, LD_LH, 32'hFFFFBEEF, 1'b0, 1'b0);
        rd("sh.lhu", 32'h10, LD_LHU, 32'h0000BEEF, 1'b0, 1'b0);
        rd("sh.lh_hi", 32'h12, LD_LH, 32'h00001234, 1'b0, 1'b0);
        rd("sh.lb3", 32'h13, LD_LB, 32'h00000012, 1'b0, 1'b0);
        rd("sh.lb0", 32'h10, LD_LB, 32'hFFFFFFEF, 1'b0, 1'b0);

        // Dropped writes: be=0 and out-of-range address.
        st(32'h10, 4'b0000, 32'h55555555);
        rd("be0.lw", 32'h10, LD_LW, 32'h1234BEEF, 1'b0, 1'b0);
        st(32'h4000, 4'b1111, 32'h11111111);
        rd("oob.rd", 32'h4000, LD_LW, 32'h0, 1'b0, 1'b1);
        rd("oob.w0", 32'h0, LD_LW, 32'h0, 1'b0, 1'b0);
        rd("oob.edge_in", 32'h3C, LD_LW, 32'h0, 1'b0, 1'b0);
        rd("oob.edge_out", 32'h40, LD_LW, 32'h0, 1'b0, 1'b1);

        // Misaligned loads and the raw-word fallback.
        rd("err.lw11", 32'h11, LD_LW, 32'h0, 1'b1, 1'b0);
        rd("err.lh11", 32'h11, LD_LH, 32'h0, 1'b1, 1'b0);
        rd("err.lhu13", 32'h13, LD_LHU, 32'h0, 1'b1, 1'b0);
        rd("raw.t7", 32'h11, 3'd7, 32'h1234BEEF, 1'b0, 1'b0);

        // Lane placement for single-byte, low-half and non-special masks.
        st(32'h23, 4'b1000, 32'h000000CD);
        rd("lane.b3", 32'h20, LD_LW, 32'hCD000000, 1'b0, 1'b0);
        st(32'h20, 4'b0011, 32'h00005678);
        rd("lane.h0", 32'h20, LD_LW, 32'hCD005678, 1'b0, 1'b0);
        st(32'h20, 4'b0110, 32'h11223344);
        rd("lane.mid", 32'h20, LD_LW, 32'hCD223378, 1'b0, 1'b0);
        st(32'h21, 4'b0010, 32'h000000F0);
        rd("lane.b1", 32'h21, LD_LBU, 32'h000000F0, 1'b0, 1'b0);

        check("sb.empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_byte_ram.md
# dm_byte_ram

Data memory for the pipelined MIPS core. Sits directly downstream of the byte-enable generator in the MEM stage: it takes the 4-bit byte-enable mask, the byte address and the raw store data, and commits byte-lane writes on the clock edge. It also returns load data aligned and extended for lw/lh/lhu/lb/lbu. After reset, it runs a self-clearing sequence that zeroes every word and holds `busy` high so the pipeline stalls.

## Interface

Parameters:
- ADDR_WIDTH, 10, word-address width; depth = 2^ADDR_WIDTH words, 4 bytes each.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- we  in  1  store request from MEM stage.
- be  in  4  byte-enable mask from the BE generator; bit i enables byte lane i, i.e. bits [8i+7:8i].
- addr  in  32  byte address (ALU result).
- wdata  in  32  raw rt value, unshifted.
- ld_type  in  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, others=raw word.
- rdata  out  32  aligned, extended load data.
- busy  out  1  clear sequence in progress; the pipeline must stall.
- oob  out  1  addr outside the array, i.e. addr[31:ADDR_WIDTH+2] != 0.
- ld_err  out  1  misaligned load.

## Operation

- State machine has two states, CLEAR and READY, plus a clear counter `cnt` of ADDR_WIDTH bits.
- Reset (rst_n low, any time, including mid-clear): state=CLEAR, cnt=0, busy=1.
- In CLEAR, each cycle writes 0 to mem[cnt], then cnt increments.
- In CLEAR, when cnt==DEPTH-1, that word is written, then state goes to READY and cnt returns to 0.
- In READY, the block stays in READY until the next reset.
- busy = (state==CLEAR); the output is driven directly from state.
- Store lane placement:
  - wdata_lane = {4{wdata[7:0]}} when be has exactly one bit set.
  - wdata_lane = {2{wdata[15:0]}} when be is 4'b0011 or 4'b1100.
  - wdata_lane = wdata otherwise.
- Write rule: in READY, with we=1, oob=0 and be!=0, lane i of mem[addr[ADDR_WIDTH+1:2]] takes wdata_lane lane i for every be[i]=1. Other lanes are unchanged.
- Dropped writes, with no state change:
  - we=1 with be=0;
  - any write in CLEAR;
  - oob=1.
- Read path is combinational: word = mem[addr[ADDR_WIDTH+1:2]].
- ld_type selects the result:
  - LH/LHU: half = addr[1] ? word[31:16] : word[15:0]; LH sign-extends, LHU zero-extends.
  - LB/LBU: byte = word[8*addr[1:0]+7 : 8*addr[1:0]]; LB sign-extends, LBU zero-extends.
  - LW and others: full word.
- ld_err = 1 for LW with addr[1:0]!=0, or LH/LHU with addr[0]=1. When ld_err=1, rdata=0.
- rdata=0 when busy=1 or oob=1.
- oob and ld_err are combinational; the caller decides on exceptions.

## Timing

- Write latency: the store is visible on rdata in the cycle after the committing edge.
- Read-during-write to the same word: rdata shows the old contents until the edge.
- Clear duration: busy is high from reset assertion through DEPTH rising edges after rst_n deasserts. busy falls after edge number DEPTH.
- Reset values:
  - busy=1, state=CLEAR, cnt=0.
  - rdata=0, driven by the busy gating.
  - oob and ld_err follow the inputs.
- Memory contents are not reset asynchronously; only the clear sequence zeroes them.
- A reset asserted mid-clear restarts at cnt=0. Partially cleared words are not relied upon.

## Structure

- Shared package `dm_pkg` holds:
  - LD_LW/LD_LH/LD_LHU/LD_LB/LD_LBU localparams (3-bit);
  - state encodings S_CLEAR/S_READY;
  - the ADDR_WIDTH default.
- The byte-enable generator imports the same package for consistency of the load/store encodings.
- One sub-module, `ld_ext`: combinational. Inputs are word, addr[1:0] and ld_type; outputs are rdata and ld_err.
- Top level holds the FSM, the counter, lane placement and the array.

## Test plan

- Clear: ADDR_WIDTH=4, preload junk via backdoor, pulse rst_n -> busy high exactly 16 cycles after release, then all 16 words read 0 with ld_type=LW.
- Word store: we=1, be=4'b1111, addr=0x10, wdata=0xDEADBEEF -> next cycle LW at 0x10 gives 0xDEADBEEF.
- Byte store and load: word at 0x10 is 0xDEADBEEF. sb with be=4'b0100, addr=0x12, wdata=0x00000080 -> word becomes 0xDE80BEEF. LB at 0x12 gives 0xFFFFFF80; LBU gives 0x00000080.
- Half store: sh with be=4'b1100, addr=0x12, wdata=0x1234 -> word becomes 0x1234BEEF. LH at 0x10 gives 0xFFFFBEEF; LHU gives 0x0000BEEF.
- Drops and errors:
  - we=1 with be=0 -> no change.
  - addr=0x4000 with ADDR_WIDTH=10 -> oob=1, no write, rdata=0.
  - LW at 0x11 -> ld_err=1, rdata=0.
- Reset mid-clear: assert rst_n low at cnt=7 -> cnt returns to 0, busy stays high for a full DEPTH cycles after release. A store attempted during busy is dropped.
